helios_stream_host: RTL and testbench

HELIOS_STREAM_HOST -- requirements
Module: helios_stream_host

---
 rtl/helios_stream_host.sv | 241 ++++++++++++++++++++++++
 tb/tb_helios_stream_host.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/helios_stream_host.sv
// Host-side framer for a streaming decoder: sends a latched syndrome as a byte frame and
// reassembles the returned correction word, with header checking and an rx idle watchdog.
module helios_stream_host #(
   parameter  int GRID_WIDTH_X   = 4,
   parameter  int GRID_WIDTH_Z   = 1,
   parameter  int GRID_WIDTH_U   = 3,
   parameter  int TIMEOUT_CYCLES = 1023,
   localparam int PPR    = GRID_WIDTH_X * GRID_WIDTH_Z,
   localparam int PU     = PPR * GRID_WIDTH_U,
   localparam int MBPR   = (PPR + 7) / 8,
   localparam int CBITS  = 2 * (GRID_WIDTH_X - 1) * GRID_WIDTH_Z + 1 + GRID_WIDTH_X * GRID_WIDTH_Z,
   localparam int CBYTES = (CBITS + 7) / 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PU-1:0]    syndrome_data,
   input  logic             syndrome_valid,
   output logic             syndrome_ready,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [CBITS-1:0] correction,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             frame_error,
   output logic             timeout
);

   localparam int RW  = $clog2(GRID_WIDTH_U + 1);
   localparam int BW  = $clog2(MBPR + 1);
   localparam int KW  = $clog2(CBYTES + 1);
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [RW-1:0]  ROUND_LAST = RW'(GRID_WIDTH_U - 1);
   localparam logic [BW-1:0]  BYTE_LAST  = BW'(MBPR - 1);
   localparam logic [KW-1:0]  RX_LAST    = KW'(CBYTES - 1);
   localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]     TX_HEADER  = 8'h01;
   localparam logic [7:0]     RX_HEADER  = 8'h02;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TX_HDR  = 3'd1,
      TX_DATA = 3'd2,
      RX_HDR  = 3'd3,
      RX_DATA = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [PU-1:0]    syn_q, syn_d;
   logic [RW-1:0]    tx_round_q, tx_round_d;
   logic [BW-1:0]    tx_byte_q, tx_byte_d;
   logic [KW-1:0]    rx_idx_q, rx_idx_d;
   logic [WDW-1:0]   wd_q, wd_d;
   logic [CBITS-1:0] corr_q, corr_d;
   logic             frame_error_q, frame_error_d;
   logic             timeout_q, timeout_d;
   logic             rst_sync_q;

   logic             tx_last_s;
   logic [KW+2:0]    rx_sh_s;
   logic [CBITS-1:0] byte_ext_s;
   logic [CBITS-1:0] byte_mask_s;
   logic [CBITS-1:0] corr_merged_s;

   // Byte `byt` of round `round`: LSB-first slice of that round, bits past the round zeroed.
   function automatic logic [7:0] tx_byte_f(input logic [PU-1:0] syn, input int round,
                                            input int byt);
      logic [7:0] b;
      int         nv;
      b  = 8'(syn >> (round * PPR + byt * 8));
      nv = PPR - byt * 8;
      if (nv < 8) begin
         b = b & 8'((9'h001 << nv) - 9'h001);
      end else begin
         b = b;
      end
      return b;
   endfunction

   // Release synchroniser: acceptance opens only from the first edge after reset deasserts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= 1'b0;
      end else begin
         rst_sync_q <= 1'b1;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         syn_q         <= '0;
         tx_round_q    <= '0;
         tx_byte_q     <= '0;
         rx_idx_q      <= '0;
         wd_q          <= '0;
         corr_q        <= '0;
         frame_error_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         syn_q         <= syn_d;
         tx_round_q    <= tx_round_d;
         tx_byte_q     <= tx_byte_d;
         rx_idx_q      <= rx_idx_d;
         wd_q          <= wd_d;
         corr_q        <= corr_d;
         frame_error_q <= frame_error_d;
         timeout_q     <= timeout_d;
      end
   end

   // Stream-facing outputs decoded from registered state.
   always_comb begin
      syndrome_ready = (state_q == IDLE) && rst_sync_q;
      tx_valid       = (state_q == TX_HDR) || (state_q == TX_DATA);
      rx_ready       = (state_q == RX_HDR) || (state_q == RX_DATA);
      result_valid   = (state_q == DONE);
      correction     = corr_q;
      frame_error    = frame_error_q;
      timeout        = timeout_q;
      if (state_q == TX_HDR) begin
         tx_data = TX_HEADER;
      end else if (state_q == TX_DATA) begin
         tx_data = tx_byte_f(syn_q, int'(tx_round_q), int'(tx_byte_q));
      end else begin
         tx_data = 8'h00;
      end
   end

   // Bytes landing beyond CBITS fall off the top of the shift and are discarded.
   always_comb begin
      tx_last_s     = (tx_round_q == ROUND_LAST) && (tx_byte_q == BYTE_LAST);
      rx_sh_s       = {rx_idx_q, 3'b000};
      byte_ext_s    = CBITS'(rx_data) << rx_sh_s;
      byte_mask_s   = CBITS'(8'hFF) << rx_sh_s;
      corr_merged_s = (corr_q & ~byte_mask_s) | byte_ext_s;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d       = state_q;
      syn_d         = syn_q;
      tx_round_d    = tx_round_q;
      tx_byte_d     = tx_byte_q;
      rx_idx_d      = rx_idx_q;
      wd_d          = wd_q;
      corr_d        = corr_q;
      frame_error_d = frame_error_q;
      timeout_d     = timeout_q;
      case (state_q)
         IDLE: begin
            if (syndrome_valid && syndrome_ready) begin
               syn_d      = syndrome_data;
               tx_round_d = '0;
               tx_byte_d  = '0;
               state_d    = TX_HDR;
            end else begin
               state_d = IDLE;
            end
         end
         TX_HDR: begin
            if (tx_ready) begin
               state_d = TX_DATA;
            end else begin
               state_d = TX_HDR;
            end
         end
         TX_DATA: begin
            if (tx_ready) begin
               if (tx_last_s) begin
                  state_d  = RX_HDR;
                  corr_d   = '0;
                  wd_d     = '0;
                  rx_idx_d = '0;
               end else if (tx_byte_q == BYTE_LAST) begin
                  tx_byte_d  = '0;
                  tx_round_d = tx_round_q + RW'(1);
               end else begin
                  tx_byte_d = tx_byte_q + BW'(1);
               end
            end else begin
               state_d = TX_DATA;
            end
         end
         RX_HDR: begin
            if (rx_valid) begin
               wd_d     = '0;
               rx_idx_d = '0;
               state_d  = RX_DATA;
               if (rx_data != RX_HEADER) begin
                  frame_error_d = 1'b1;
               end else begin
                  frame_error_d = frame_error_q;
               end
            end else if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         RX_DATA: begin
            if (rx_valid) begin
               wd_d   = '0;
               corr_d = corr_merged_s;
               if (rx_idx_q == RX_LAST) begin
                  state_d = DONE;
               end else begin
                  rx_idx_d = rx_idx_q + KW'(1);
               end
            end else if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         DONE: begin
            if (result_ready) begin
               state_d       = IDLE;
               frame_error_d = 1'b0;
               timeout_d     = 1'b0;
               wd_d          = '0;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_helios_stream_host.sv
// Scoreboard bench for helios_stream_host: stimulus queues expected tx bytes and results,
// a forked monitor pops and compares them whenever the DUT hands something over.
module tb_helios_stream_host;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] syndrome_data;
   logic        syndrome_valid;
   logic        syndrome_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [10:0] correction;
   logic        result_valid;
   logic        result_ready;
   logic        frame_error;
   logic        timeout;

   always #5 clk = ~clk;

   helios_stream_host dut (
      .clk            (clk),
      .reset          (reset),
      .syndrome_data  (syndrome_data),
      .syndrome_valid (syndrome_valid),
      .syndrome_ready (syndrome_ready),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .correction     (correction),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .frame_error    (frame_error),
      .timeout        (timeout)
   );

   typedef struct packed {
      logic [10:0] corr;
      logic        fe;
      logic        to;
   } res_t;

   logic [7:0] exp_tx[$];
   res_t       exp_res[$];
   logic [7:0] rx_src[$];

   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;
   int   first_rv = -1;
   int   hs_cyc = 0;
   int   res_hold = 0;
   bit   tx_toggle = 1'b0;
   bit   syn_take, rx_take, res_take;
   bit   tx_held_v = 1'b0;
   logic [7:0] tx_held;
   bit   res_held_v = 1'b0;
   res_t res_held;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      res_t       cur;
      res_t       e;
      logic [7:0] eb;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            tx_held_v  = 1'b0;
            res_held_v = 1'b0;
         end else begin
            if (tx_valid) begin
               if (tx_held_v) chk("tx_stall_hold", 32'(tx_data), 32'(tx_held));
               if (tx_ready) begin
                  tx_held_v = 1'b0;
                  if (exp_tx.size() == 0) begin
                     vec_cnt++;
                     err_cnt++;
                     $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
                  end else begin
                     eb = exp_tx.pop_front();
                     chk("tx_byte", 32'(tx_data), 32'(eb));
                  end
               end else begin
                  tx_held_v = 1'b1;
                  tx_held   = tx_data;
               end
            end else begin
               tx_held_v = 1'b0;
            end
            if (result_valid) begin
               cur = {correction, frame_error, timeout};
               chk("busy_syn_ready", 32'(syndrome_ready), 32'h0);
               if (res_held_v) chk("result_hold", 32'(cur), 32'(res_held));
               if (result_ready) begin
                  res_held_v = 1'b0;
                  if (exp_res.size() == 0) begin
                     vec_cnt++;
                     err_cnt++;
                     $display("FAIL result_unexpected: got 0x%0h, expected no result", cur);
                  end else begin
                     e = exp_res.pop_front();
                     chk("result_corr", 32'(correction), 32'(e.corr));
                     chk("result_frame_error", 32'(frame_error), 32'(e.fe));
                     chk("result_timeout", 32'(timeout), 32'(e.to));
                  end
               end else begin
                  res_held_v = 1'b1;
                  res_held   = cur;
               end
            end else begin
               res_held_v = 1'b0;
            end
         end
      end
   endtask

   task automatic drive_rx();
      rx_valid = (rx_src.size() != 0);
      rx_data  = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
   endtask

   // One clock: sample handshakes on the falling edge, update inputs just after the rising edge.
   task automatic step();
      @(negedge clk);
      syn_take = syndrome_valid && syndrome_ready;
      rx_take  = rx_valid && rx_ready;
      res_take = result_valid && result_ready;
      if (result_valid && first_rv < 0) first_rv = cyc;
      @(posedge clk);
      #1;
      cyc++;
      if (rx_take) void'(rx_src.pop_front());
      drive_rx();
      tx_ready = tx_toggle ? ~tx_ready : 1'b1;
      if (result_valid && res_hold > 0) begin
         result_ready = 1'b0;
         res_hold--;
      end else begin
         result_ready = 1'b1;
      end
   endtask

   task automatic run_frame(input logic [11:0] syn, input logic [23:0] txd,
                            input logic [23:0] rxd, input int n_rx, input bit tog,
                            input int hold, input logic [10:0] ecorr, input logic efe,
                            input logic eto, input int elat);
      int n;
      bit took;
      bit done;
      exp_tx.push_back(8'h01);
      for (int k = 0; k < 3; k++) exp_tx.push_back(txd[8*k +: 8]);
      exp_res.push_back({ecorr, efe, eto});
      for (int k = 0; k < n_rx; k++) rx_src.push_back(rxd[8*k +: 8]);
      drive_rx();
      tx_toggle      = tog;
      res_hold       = hold;
      first_rv       = -1;
      syndrome_data  = syn;
      syndrome_valid = 1'b1;
      took = 1'b0;
      n    = 0;
      while (!took && n < 20) begin
         step();
         n++;
         if (syn_take) took = 1'b1;
      end
      syndrome_valid = 1'b0;
      hs_cyc = cyc - 1;
      chk("syn_accept", 32'(took), 32'h1);
      done = 1'b0;
      n    = 0;
      while (!done && n < 3000) begin
         step();
         n++;
         if (res_take) done = 1'b1;
      end
      chk("result_seen", 32'(done), 32'h1);
      if (elat >= 0) chk("latency", 32'(first_rv - hs_cyc), 32'(elat));
      chk("idle_syn_ready", 32'(syndrome_ready), 32'h1);
      chk("idle_result_valid", 32'(result_valid), 32'h0);
      chk("idle_frame_error", 32'(frame_error), 32'h0);
      chk("idle_timeout", 32'(timeout), 32'h0);
      chk("rx_leftover", 32'(rx_src.size()), 32'h0);
      tx_toggle = 1'b0;
   endtask

   initial begin
      int n;
      reset          = 1'b0;
      syndrome_valid = 1'b0;
      syndrome_data  = 12'h000;
      tx_ready       = 1'b1;
      rx_valid       = 1'b0;
      rx_data        = 8'h00;
      result_ready   = 1'b1;
      fork
         monitor();
      join_none

      #23;
      chk("rst_syn_ready", 32'(syndrome_ready), 32'h0);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_rx_ready", 32'(rx_ready), 32'h0);
      chk("rst_result_valid", 32'(result_valid), 32'h0);
      chk("rst_flags", 32'({frame_error, timeout}), 32'h0);
      chk("rst_correction", 32'(correction), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("release_syn_ready", 32'(syndrome_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("sync_syn_ready", 32'(syndrome_ready), 32'h1);

      // Baseline frame, zero stalls.
      run_frame(12'hA5C, 24'h0A050C, 24'h053F02, 3, 1'b0, 0, 11'h53F, 1'b0, 1'b0, 8);
      // Same frame with tx_ready toggling.
      run_frame(12'hA5C, 24'h0A050C, 24'h053F02, 3, 1'b1, 0, 11'h53F, 1'b0, 1'b0, -1);
      // Bad rx header; top byte 0xFF truncated to 3 bits.
      run_frame(12'h0F0, 24'h000F00, 24'hFFAA7E, 3, 1'b0, 0, 11'h7AA, 1'b1, 1'b0, 8);
      // rx stream stops after header: 5 cycles to reach RX_DATA plus 1023 idle + 1 to DONE.
      run_frame(12'h000, 24'h000000, 24'h000002, 1, 1'b0, 0, 11'h000, 1'b0, 1'b1, 1029);

      // Reset while data byte 2 of the tx frame is on offer.
      exp_tx.push_back(8'h01);
      exp_tx.push_back(8'h0C);
      exp_tx.push_back(8'h05);
      syndrome_data  = 12'hA5C;
      syndrome_valid = 1'b1;
      n = 0;
      syn_take = 1'b0;
      while (!syn_take && n < 20) begin
         step();
         n++;
      end
      syndrome_valid = 1'b0;
      repeat (3) step();
      chk("abort_tx_valid_before", 32'(tx_valid), 32'h1);
      chk("abort_byte2", 32'(tx_data), 32'h0A);
      reset = 1'b0;
      #1;
      chk("abort_tx_valid", 32'(tx_valid), 32'h0);
      chk("abort_tx_data", 32'(tx_data), 32'h0);
      chk("abort_syn_ready", 32'(syndrome_ready), 32'h0);
      chk("abort_rx_ready", 32'(rx_ready), 32'h0);
      chk("abort_result_valid", 32'(result_valid), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("abort_release_syn_ready", 32'(syndrome_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("abort_sync_syn_ready", 32'(syndrome_ready), 32'h1);
      chk("abort_txq_drained", 32'(exp_tx.size()), 32'h0);
      run_frame(12'h3C7, 24'h030C07, 24'h061102, 3, 1'b0, 0, 11'h611, 1'b0, 1'b0, 8);

      // Consumer holds result_ready low for 5 cycles.
      run_frame(12'hFFF, 24'h0F0F0F, 24'h070002, 3, 1'b0, 5, 11'h700, 1'b0, 1'b0, 8);

      repeat (2) step();
      chk("txq_empty", 32'(exp_tx.size()), 32'h0);
      chk("resq_empty", 32'(exp_res.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
